// File: rtl/mux2a1_pkg.sv
// Shared constants for the mux2a1 selector: default data width and the reset value of the registered path.
package mux2a1_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 1;
    localparam int unsigned DEFAULT_RESET_VAL = 0;

    typedef enum logic {
        SEL_D0 = 1'b0,
        SEL_D1 = 1'b1
    } sel_e;

endpackage : mux2a1_pkg

// File: rtl/mux2a1_core.sv
// Combinational WIDTH-bit 2:1 selector; an unknown select merges the two inputs bit by bit.
module mux2a1_core
    import mux2a1_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    // The conditional operator yields d0 where d0 and d1 agree and X where they differ when s is X.
    assign y = (sel_e'(s) == SEL_D1) ? d1 : d0;

endmodule : mux2a1_core

// File: rtl/mux2a1.sv
// 2:1 data selector with a combinational output Y and an enable-gated registered copy y_q plus a sticky valid flag.
module mux2a1
    import mux2a1_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_valid
);

    mux2a1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d0 (D0),
        .d1 (D1),
        .s  (S),
        .y  (Y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= RESET_VAL;
            y_valid <= 1'b0;
        end else if (en) begin
            y_q     <= Y;
            y_valid <= 1'b1;
        end
    end

endmodule : mux2a1

// File: tb/tb_mux2a1.sv
// Self-checking bench for mux2a1: WIDTH=1 truth table plus WIDTH=8 registered, reset and randomized checks.
module tb_mux2a1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance: combinational truth table only
    logic a_d0, a_d1, a_s, a_y, a_yq, a_valid;
    logic a_rst = 1'b0;
    logic a_en  = 1'b0;

    mux2a1 #(.WIDTH(1)) u_w1 (
        .clk     (clk),
        .rst     (a_rst),
        .D0      (a_d0),
        .D1      (a_d1),
        .S       (a_s),
        .en      (a_en),
        .Y       (a_y),
        .y_q     (a_yq),
        .y_valid (a_valid)
    );

    // WIDTH=8 instance
    logic [7:0] d0, d1, y, y_q;
    logic       s, en, rst, y_valid;

    mux2a1 #(.WIDTH(8)) u_w8 (
        .clk     (clk),
        .rst     (rst),
        .D0      (d0),
        .D1      (d1),
        .S       (s),
        .en      (en),
        .Y       (y),
        .y_q     (y_q),
        .y_valid (y_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic d0;
        logic d1;
        logic s;
        logic y;
    } tt_vec_t;

    // Reference selection by indexing the pair of inputs with the select value.
    function automatic logic [7:0] pick(input logic [7:0] x0, input logic [7:0] x1, input logic sel);
        logic [7:0] pair [2];
        pair[0] = x0;
        pair[1] = x1;
        return pair[int'(sel)];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tt_vec_t    tt [8];
        logic [7:0] m_q;
        logic       m_valid;

        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tt[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tt[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tt[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tt[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; en = 1'b0; s = 1'b0; d0 = 8'h00; d1 = 8'h00;
        a_d0 = 1'b0; a_d1 = 1'b0; a_s = 1'b0;
        #1;
        check("reset_yq", y_q, 8'h00);
        check("reset_valid", {7'd0, y_valid}, 8'h00);

        for (int i = 0; i < 8; i++) begin
            a_d0 = tt[i].d0; a_d1 = tt[i].d1; a_s = tt[i].s;
            #1;
            check($sformatf("truth_%0d", i), {7'd0, a_y}, {7'd0, tt[i].y});
        end

        // Back-to-back change in a single timestep
        a_d0 = 1'b1; a_d1 = 1'b1; a_s = 1'b0;
        #1;
        check("b2b_before", {7'd0, a_y}, 8'h01);
        a_d0 = 1'b0; a_d1 = 1'b0; a_s = 1'b1;
        #1;
        check("b2b_after", {7'd0, a_y}, 8'h00);

        // Reset held across an edge with en=1 keeps the register clear
        @(negedge clk);
        en = 1'b1; s = 1'b1; d0 = 8'h5A; d1 = 8'hA5;
        #1;
        check("y_during_reset", y, 8'hA5);
        @(posedge clk); #1;
        check("hold_in_reset_yq", y_q, 8'h00);
        check("hold_in_reset_valid", {7'd0, y_valid}, 8'h00);

        // Registered capture
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("capture_yq", y_q, 8'hA5);
        check("capture_valid", {7'd0, y_valid}, 8'h01);

        @(negedge clk);
        s = 1'b0; en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("hold_yq", y_q, 8'hA5);
        check("hold_valid", {7'd0, y_valid}, 8'h01);
        check("hold_y", y, 8'h5A);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_yq", y_q, 8'h00);
        check("async_rst_valid", {7'd0, y_valid}, 8'h00);
        check("async_rst_y", y, 8'h5A);

        // Release: first edge captures
        @(negedge clk);
        rst = 1'b0; en = 1'b1; s = 1'b0; d0 = 8'h3C;
        @(posedge clk); #1;
        check("release_yq", y_q, 8'h3C);
        check("release_valid", {7'd0, y_valid}, 8'h01);

        // Randomized run against an enable-gated, one-cycle-delayed model
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        #1;
        m_q = 8'h00; m_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 24) == 0);
            en  = 1'($urandom);
            s   = 1'($urandom);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            #1;
            check("rand_y", y, pick(d0, d1, s));
            if (rst) begin
                m_q = 8'h00; m_valid = 1'b0;
                check("rand_async_yq", y_q, m_q);
                check("rand_async_valid", {7'd0, y_valid}, {7'd0, m_valid});
            end
            @(posedge clk);
            if (!rst && en) begin
                m_q = pick(d0, d1, s);
                m_valid = 1'b1;
            end
            #1;
            check("rand_yq", y_q, m_q);
            check("rand_valid", {7'd0, y_valid}, {7'd0, m_valid});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mux2a1

// File: doc/mux2a1.md
Name: mux2a1

Overview:
- Parameterizable 2-to-1 data selector with a combinational path and a registered path.
- The combinational output Y follows the select immediately and is used by glue logic and lab-level truth-table benches.
- The registered output y_q gives a one-cycle, reset-clean version of the selection for synchronous consumers downstream.
- Leaf datapath block; it holds no protocol state beyond the output register and the valid flag.

Parameters:
- WIDTH, 1, bit width of D0, D1, Y and y_q.
- RESET_VAL, 0 (WIDTH bits), value loaded into y_q while rst is high.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous active-high reset; clears the registered path only.
- D0  input  WIDTH  data input selected when S=0.
- D1  input  WIDTH  data input selected when S=1.
- S  input  1  select line.
- en  input  1  capture enable for the registered path.
- Y  output  WIDTH  combinational result, S ? D1 : D0.
- y_q  output  WIDTH  registered result.
- y_valid  output  1  high when y_q holds at least one captured selection since reset.

Behaviour:
- Y is purely combinational: Y = D0 when S=0, Y = D1 when S=1.
  - Y has no dependence on clk, rst or en.
  - Y changes within the same delta/timestep as any input change.
- X/Z on S: Y = D0 where D0 and D1 bits agree, X where they differ. Synthesis treats S as binary.
- Registered path, on the rising edge of clk with rst low:
  - en=1: y_q <= (S ? D1 : D0) and y_valid <= 1.
  - en=0: y_q and y_valid hold.
- Latency: y_q reflects the inputs sampled at the edge, one cycle after presentation.
- Reset: rst high forces y_q = RESET_VAL and y_valid = 0 immediately, with no clock edge needed.
  - Both registers stay at those values while rst is held high.
  - Y keeps operating during reset.
- Reset release: the first edge with rst low and en=1 captures normally; there is no extra wait cycle.
- Reset asserted mid-operation: any pending capture is discarded. The next capture requires en=1 after release.
- Simultaneous change of S and data: Y settles to the final selection; no ordering requirement exists between S and D changes.
- Width: no truncation or extension; all data ports are exactly WIDTH bits.
- There is no full/empty or wrap-around condition. y_valid is sticky until reset.

Decomposition:
- Shared package: the WIDTH default constant and the RESET_VAL default constant.
- One natural sub-module: mux2a1_core, the combinational WIDTH-bit selector.
  - Instantiated once to drive Y.
  - Its output feeds the y_q register inside mux2a1.
- The register, enable and valid logic stay in the top module.

Test Plan:
- Truth table at WIDTH=1, rst low, each combination held 1 time unit:
  - (D0,D1,S) = (0,0,0)->Y=0, (0,1,0)->0, (1,0,0)->1, (1,1,0)->1.
  - (0,0,1)->0, (0,1,1)->1, (1,0,1)->0, (1,1,1)->1.
- Zero-delay back-to-back input change from (1,1,0) to (0,0,1) in one timestep -> Y=0 with no intermediate latched value.
- Registered capture at WIDTH=8: D0=0x5A, D1=0xA5, S=1, en=1, one clk edge -> y_q=0xA5, y_valid=1. Then S=0 with en=0 for 2 edges -> y_q stays 0xA5 while Y=0x5A.
- Async reset mid-run: with y_q=0xA5, assert rst between edges -> y_q=0x00 and y_valid=0 before the next edge, while Y still equals the selected input.
- Reset release: deassert rst, en=1, S=0, D0=0x3C -> y_q=0x3C and y_valid=1 after the first edge.
- Randomized 1000 cycles at WIDTH=8 with random en/S/D and occasional rst -> Y matches the reference expression every timestep; y_q matches a one-cycle-delayed, enable-gated model.
